// File: rtl/alu_cmd_sequencer.sv
// Replays one ALU command (dato1, dato2, opcode) onto the input_output switch bus
// with registered button strobes, then samples w_salida and returns it on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int NB_IN   = 8,
    parameter int NB_CODE = 6,
    parameter int N_SETUP = 2,
    parameter int N_HOLD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_IN-1:0]   i_dato1,
    input  logic [NB_IN-1:0]   i_dato2,
    input  logic [NB_CODE-1:0] i_code,
    output logic [NB_IN-1:0]   o_switch,
    output logic               o_b_dato1,
    output logic               o_b_dato2,
    output logic               o_b_code,
    input  logic [NB_IN-1:0]   i_salida,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_IN-1:0]   o_result
);

    typedef enum logic [3:0] {
        IDLE, SET_D1, STB_D1, SET_D2, STB_D2, SET_OP, STB_OP, WAIT_RES, DONE
    } state_t;

    localparam int N_WAIT = N_SETUP + 1;
    localparam int N_MAX  = (N_WAIT > N_HOLD) ? N_WAIT : N_HOLD;
    localparam int CNT_W  = $clog2(N_MAX + 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n, phase_last;
    logic                 phase_done, accept;
    logic [NB_IN-1:0]     d1_q, d2_q, d1_n;
    logic [NB_CODE-1:0]   code_q;

    logic [NB_IN-1:0]     switch_n, result_n;
    logic                 b_dato1_n, b_dato2_n, b_code_n, valid_n;

    // State register; outputs are registered here too so strobes are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            code_q    <= '0;
            o_switch  <= '0;
            o_b_dato1 <= 1'b0;
            o_b_dato2 <= 1'b0;
            o_b_code  <= 1'b0;
            o_valid   <= 1'b0;
            o_result  <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic so all flops update from pre-edge values.
            state     <= state_n;
            cnt       <= cnt_n;
            if (accept) begin
                d1_q   <= i_dato1;
                d2_q   <= i_dato2;
                code_q <= i_code;
            end
            o_switch  <= switch_n;
            o_b_dato1 <= b_dato1_n;
            o_b_dato2 <= b_dato2_n;
            o_b_code  <= b_code_n;
            o_valid   <= valid_n;
            o_result  <= result_n;
        end
    end

    // Next-state and phase counter.
    always_comb begin
        // NOTE: every comb output gets a default first, otherwise a latch is inferred.
        state_n    = state;
        phase_last = '0;
        case (state)
            SET_D1, SET_D2, SET_OP: phase_last = CNT_W'(N_SETUP - 1);
            STB_D1, STB_D2, STB_OP: phase_last = CNT_W'(N_HOLD - 1);
            WAIT_RES:               phase_last = CNT_W'(N_WAIT - 1);
            default:                phase_last = '0;
        endcase
        phase_done = (cnt == phase_last);
        accept     = (state == IDLE) && i_valid;

        case (state)
            IDLE:     if (i_valid) state_n = SET_D1;
            SET_D1:   if (phase_done) state_n = STB_D1;
            STB_D1:   if (phase_done) state_n = SET_D2;
            SET_D2:   if (phase_done) state_n = STB_D2;
            STB_D2:   if (phase_done) state_n = SET_OP;
            SET_OP:   if (phase_done) state_n = STB_OP;
            STB_OP:   if (phase_done) state_n = WAIT_RES;
            WAIT_RES: if (phase_done) state_n = DONE;
            DONE:     if (o_valid && i_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase

        if (state_n != state || state == IDLE || state == DONE) cnt_n = '0;
        else                                                   cnt_n = cnt + CNT_W'(1);
    end

    // Output decode: next values of the registered outputs, aligned with state_n.
    always_comb begin
        o_ready   = (state == IDLE);
        d1_n      = accept ? i_dato1 : d1_q;
        switch_n  = o_switch;
        case (state_n)
            SET_D1, STB_D1: switch_n = d1_n;
            SET_D2, STB_D2: switch_n = d2_q;
            SET_OP, STB_OP: switch_n = NB_IN'(code_q);
            default:        switch_n = o_switch;
        endcase
        b_dato1_n = (state_n == STB_D1);
        b_dato2_n = (state_n == STB_D2);
        b_code_n  = (state_n == STB_OP);
        // o_valid follows DONE by one cycle and drops on the handshake edge.
        valid_n   = (state == DONE) && (state_n == DONE);
        result_n  = (state == WAIT_RES && phase_done) ? i_salida : o_result;
    end

endmodule
